// File: rtl/qy_mul_reconstruct.sv
// -----------------------------------------------------------------------------
// qy_mul_reconstruct
//
// Rebuilds a dividend from divider results, x = q*y + r, using a sequential
// shift-add multiply-accumulate that consumes one quotient bit per cycle,
// LSB first. It is the companion of the 16/8 array divider. Self-check and
// error-characterisation paths use it to measure how far approximate
// quotients and remainders drift from the original dividend.
//
// The lowest APPROX_ITERS iterations can accumulate with a bitwise OR instead
// of an add. This mirrors the divider's approximate low stages.
//
// Parameters
//   W            operand width of q, y and r; x is 2*W bits
//   APPROX_ITERS number of LSB iterations (0..W) that OR-accumulate; 0 = exact
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand set valid
//   in_ready   out  block can accept operands (IDLE only)
//   q          in   [W]   quotient from divider
//   y          in   [W]   divisor
//   r          in   [W]   remainder from divider
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer accepts result
//   x          out  [2W]  reconstructed dividend
//   r_ge_y     out  r >= y, i.e. remainder inconsistent (also 1 when y = 0)
//
// Timing: accept on edge E0, iterations on E1..EW, and out_valid is visible
// after EW. Back-to-back throughput is one result per W+2 cycles.
// -----------------------------------------------------------------------------
module qy_mul_reconstruct #(
    parameter int unsigned W            = 8,
    parameter int unsigned APPROX_ITERS = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   q,
    input  logic [W-1:0]   y,
    input  logic [W-1:0]   r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] x,
    output logic           r_ge_y
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    // Bit i set means iteration i OR-accumulates instead of adding.
    localparam logic [W-1:0] ApproxMask = W'((64'(1) << APPROX_ITERS) - 64'(1));

    if (APPROX_ITERS > W) begin : g_bad_approx_iters
        $error("qy_mul_reconstruct: APPROX_ITERS (%0d) must not exceed W (%0d)",
               APPROX_ITERS, W);
    end

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [2*W-1:0]  acc_q,   acc_d;
    logic [CntW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]    q_q,     q_d;
    logic [W-1:0]    y_q,     y_d;
    logic [2*W-1:0]  x_q,     x_d;
    logic            r_ge_y_q, r_ge_y_d;

    // Datapath for the current iteration.
    logic [2*W-1:0] y_shift;
    logic [2*W-1:0] acc_next;
    logic           cnt_last;
    logic           approx_iter;

    always_comb begin
        y_shift     = {{W{1'b0}}, y_q} << cnt_q;
        approx_iter = ApproxMask[cnt_q];
        cnt_last    = (cnt_q == CntW'(W - 1));
        acc_next    = acc_q;
        if (q_q[cnt_q]) begin
            if (approx_iter) begin
                acc_next = acc_q | y_shift;
            end else begin
                // Cannot overflow: (2^W-1)^2 + 2^W-1 < 2^(2W).
                acc_next = acc_q + y_shift;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        y_d      = y_q;
        x_d      = x_q;
        r_ge_y_d = r_ge_y_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    q_d      = q;
                    y_d      = y;
                    acc_d    = {{W{1'b0}}, r};
                    r_ge_y_d = (r >= y);
                    cnt_d    = '0;
                    state_d  = StMul;
                end
            end
            StMul: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    x_d     = acc_next;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                // The consuming edge only returns to IDLE. A new operand is
                // accepted no earlier than the following edge.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
            y_q      <= '0;
            x_q      <= '0;
            r_ge_y_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            y_q      <= y_d;
            x_q      <= x_d;
            r_ge_y_q <= r_ge_y_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign x         = x_q;
    assign r_ge_y    = r_ge_y_q;

endmodule

// File: tb/tb_qy_mul_reconstruct.sv
// Bench for qy_mul_reconstruct: three instances (exact, 2 approximate LSB
// iterations, fully OR-accumulated) driven in lockstep from shared inputs.
module tb_qy_mul_reconstruct;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] q, y, r;

    logic        in_ready_e, out_valid_e, r_ge_y_e;
    logic        in_ready_a, out_valid_a, r_ge_y_a;
    logic        in_ready_o, out_valid_o, r_ge_y_o;
    logic [15:0] x_e, x_a, x_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qy_mul_reconstruct #(.W(8), .APPROX_ITERS(0)) dut_exact (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_e),
        .q(q), .y(y), .r(r), .out_valid(out_valid_e), .out_ready(out_ready),
        .x(x_e), .r_ge_y(r_ge_y_e)
    );

    qy_mul_reconstruct #(.W(8), .APPROX_ITERS(2)) dut_apx2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .q(q), .y(y), .r(r), .out_valid(out_valid_a), .out_ready(out_ready),
        .x(x_a), .r_ge_y(r_ge_y_a)
    );

    qy_mul_reconstruct #(.W(8), .APPROX_ITERS(8)) dut_or (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o),
        .q(q), .y(y), .r(r), .out_valid(out_valid_o), .out_ready(out_ready),
        .x(x_o), .r_ge_y(r_ge_y_o)
    );

    // Reference: x = r + sum over set quotient bits of (y << i), with the
    // lowest 'approx' terms merged by OR instead of added.
    function automatic logic [15:0] model_x(input logic [7:0] qv, input logic [7:0] yv,
                                            input logic [7:0] rv, input int approx);
        logic [15:0] acc;
        logic [15:0] term;
        acc = 16'(rv);
        for (int i = 0; i < 8; i++) begin
            if (qv[i]) begin
                term = 16'(yv) << i;
                if (i < approx) acc = acc | term;
                else            acc = acc + term;
            end
        end
        return acc;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Present one operand set and wait for the result. Returns at a negedge
    // with out_valid high (unless timed out) and out_ready still low.
    task automatic start_and_wait(input logic [7:0] qv, input logic [7:0] yv,
                                  input logic [7:0] rv, output int lat, output bit tmo);
        int n;
        n = 0;
        while (!in_ready_e && n < 50) begin
            @(negedge clk);
            n++;
        end
        q = qv; y = yv; r = rv; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid_e && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        tmo = !out_valid_e;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  q, y, r;
        logic [15:0] x_exact;
        logic [15:0] x_apx2;
        logic        ge;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          lat;
        bit          tmo;
        logic [15:0] xs, held_x;
        logic        held_ge;
        logic [7:0]  hi, yy;
        logic [15:0] xv;

        vecs[0] = '{q: 8'h12, y: 8'h34, r: 8'h05, x_exact: 16'h03AD, x_apx2: 16'h03AD, ge: 1'b0};
        vecs[1] = '{q: 8'hFF, y: 8'hFF, r: 8'hFE, x_exact: 16'hFEFF, x_apx2: 16'hFD03, ge: 1'b0};
        vecs[2] = '{q: 8'hFF, y: 8'hFF, r: 8'hFF, x_exact: 16'hFF00, x_apx2: 16'hFD03, ge: 1'b1};
        vecs[3] = '{q: 8'h03, y: 8'h03, r: 8'h00, x_exact: 16'h0009, x_apx2: 16'h0007, ge: 1'b0};
        vecs[4] = '{q: 8'h02, y: 8'h07, r: 8'h01, x_exact: 16'h000F, x_apx2: 16'h000F, ge: 1'b0};
        vecs[5] = '{q: 8'h00, y: 8'h5A, r: 8'h33, x_exact: 16'h0033, x_apx2: 16'h0033, ge: 1'b0};
        vecs[6] = '{q: 8'h9C, y: 8'h00, r: 8'h27, x_exact: 16'h0027, x_apx2: 16'h0027, ge: 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; q = '0; y = '0; r = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready_e), 32'd1);
        check("reset_out_valid", 32'(out_valid_e), 32'd0);
        check("reset_x", 32'(x_e), 32'd0);
        check("reset_r_ge_y", 32'(r_ge_y_e), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            start_and_wait(vecs[i].q, vecs[i].y, vecs[i].r, lat, tmo);
            check($sformatf("vec%0d_timeout", i), 32'(tmo), 32'd0);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d_x_exact", i), 32'(x_e), 32'(vecs[i].x_exact));
            check($sformatf("vec%0d_x_apx2", i), 32'(x_a), 32'(vecs[i].x_apx2));
            check($sformatf("vec%0d_x_or", i), 32'(x_o),
                  32'(model_x(vecs[i].q, vecs[i].y, vecs[i].r, 8)));
            check($sformatf("vec%0d_r_ge_y", i), 32'(r_ge_y_e), 32'(vecs[i].ge));
            consume();
        end

        // Backpressure: result held, in_ready low, in_valid pulses ignored.
        start_and_wait(8'h21, 8'h43, 8'h11, lat, tmo);
        check("bp_timeout", 32'(tmo), 32'd0);
        held_x  = x_e;
        held_ge = r_ge_y_e;
        check("bp_x", 32'(held_x), 32'(16'h21 * 16'h43 + 16'h11));
        for (int c = 0; c < 5; c++) begin
            q = 8'(c + 1); y = 8'h01; r = 8'hEE; in_valid = c[0];
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp%0d_out_valid", c), 32'(out_valid_e), 32'd1);
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready_e), 32'd0);
            check($sformatf("bp%0d_x_held", c), 32'(x_e), 32'(held_x));
            check($sformatf("bp%0d_ge_held", c), 32'(r_ge_y_e), 32'(held_ge));
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_out_valid", 32'(out_valid_e), 32'd0);
        check("bp_release_in_ready", 32'(in_ready_e), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_no_accept_in_ready", 32'(in_ready_e), 32'd1);

        // Asynchronous reset in the 4th MUL cycle.
        q = 8'hAA; y = 8'h55; r = 8'h10; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid_e), 32'd0);
        check("rst_mid_x", 32'(x_e), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready_e), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_and_wait(8'h02, 8'h07, 8'h01, lat, tmo);
        check("post_rst_timeout", 32'(tmo), 32'd0);
        check("post_rst_x", 32'(x_e), 32'h000F);
        consume();

        // Random round trip through an ideal divider, y > x[15:8] so q fits.
        for (int n = 0; n < 1000; n++) begin
            xv = 16'($urandom_range(0, 16'hFEFF));
            hi = xv[15:8];
            yy = 8'($urandom_range(32'(hi) + 1, 255));
            start_and_wait(8'(xv / 16'(yy)), yy, 8'(xv % 16'(yy)), lat, tmo);
            check($sformatf("rnd%0d_timeout", n), 32'(tmo), 32'd0);
            check($sformatf("rnd%0d_x", n), 32'(x_e), 32'(xv));
            check($sformatf("rnd%0d_r_ge_y", n), 32'(r_ge_y_e), 32'd0);
            xs = model_x(8'(xv / 16'(yy)), yy, 8'(xv % 16'(yy)), 2);
            check($sformatf("rnd%0d_x_apx2", n), 32'(x_a), 32'(xs));
            xs = model_x(8'(xv / 16'(yy)), yy, 8'(xv % 16'(yy)), 8);
            check($sformatf("rnd%0d_x_or", n), 32'(x_o), 32'(xs));
            consume();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
